i2c_slave_mem: RTL and testbench

//  Synthesizable I2C slave with a small byte-addressed register file. It sits downstream of

---
 rtl/i2c_slave_pkg.sv | 22 ++
 rtl/i2c_slave_mem_bus_sync.sv | 44 ++++
 rtl/i2c_slave_mem.sv | 189 ++++++++++++++++++
 tb/tb_i2c_slave_mem.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// rtl/i2c_slave_pkg.sv - shared types and constants for the i2c_slave_mem slave
package i2c_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_slave_state_e;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic ACK          = 1'b0;
    localparam logic NACK         = 1'b1;

    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_slave_mem_bus_sync.sv
// rtl/i2c_slave_mem_bus_sync.sv - scl/sda synchronizers and bus event pulses
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;

    // Idle bus is high, so resetting to 1 avoids phantom edges after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s_o    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s_o;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s_o;

endmodule

// File: rtl/i2c_slave_mem.sv
// rtl/i2c_slave_mem.sv - I2C slave with an EEPROM-style byte-addressed register file
module i2c_slave_mem
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h22,
    parameter int         DATA_WIDTH  = 8,
    parameter int         MEM_DEPTH   = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        AW          = $clog2(MEM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_o,
    output logic                  busy_o,
    output logic                  wr_strobe_o,
    output logic [AW-1:0]         wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  rd_strobe_o,
    output logic [AW-1:0]         rd_addr_o
);

    logic sda_s, scl_rise, scl_fall, bus_start, bus_stop;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_s_o    (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (bus_start),
        .stop_o     (bus_stop)
    );

    i2c_slave_state_e      state_q;
    logic [3:0]            bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [AW-1:0]         ptr_q;
    logic                  first_byte_q;
    logic                  master_ack_q;
    logic                  sda_q;
    logic                  busy_q;
    logic                  wr_strobe_q;
    logic [AW-1:0]         wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  rd_strobe_q;
    logic [AW-1:0]         rd_addr_q;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // General call is never answered, even if SLAVE_ADDR is set to zero.
    logic addr_match;
    assign addr_match = (shift_q[7:1] == SLAVE_ADDR) && (SLAVE_ADDR != 7'h00);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            ptr_q        <= '0;
            first_byte_q <= 1'b0;
            master_ack_q <= NACK;
            sda_q        <= 1'b1;
            busy_q       <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_strobe_q  <= 1'b0;
            rd_addr_q    <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            if (bus_stop) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= '0;
                sda_q     <= 1'b1;
                busy_q    <= 1'b0;
            end else if (bus_start) begin
                state_q   <= ST_ADDR;
                bit_cnt_q <= '0;
                sda_q     <= 1'b1;
            end else begin
                case (state_q)
                    ST_ADDR: begin
                        if (scl_rise && bit_cnt_q < BITS_PER_BYTE) begin
                            shift_q   <= {shift_q[DATA_WIDTH-2:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
                            if (addr_match) begin
                                state_q <= ST_ADDR_ACK;
                                sda_q   <= ACK;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt_q <= '0;
                            if (shift_q[0] == I2C_RW_WRITE) begin
                                state_q      <= ST_WR_BYTE;
                                sda_q        <= 1'b1;
                                first_byte_q <= 1'b1;
                            end else begin
                                state_q     <= ST_RD_BYTE;
                                shift_q     <= mem_q[ptr_q];
                                sda_q       <= mem_q[ptr_q][DATA_WIDTH-1];
                                rd_strobe_q <= 1'b1;
                                rd_addr_q   <= ptr_q;
                            end
                        end
                    end
                    ST_WR_BYTE: begin
                        if (scl_rise && bit_cnt_q < BITS_PER_BYTE) begin
                            shift_q   <= {shift_q[DATA_WIDTH-2:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
                            state_q <= ST_WR_ACK;
                            sda_q   <= ACK;
                            if (first_byte_q) begin
                                ptr_q        <= shift_q[AW-1:0];
                                first_byte_q <= 1'b0;
                            end else begin
                                mem_q[ptr_q] <= shift_q;
                                wr_strobe_q  <= 1'b1;
                                wr_addr_q    <= ptr_q;
                                wr_data_q    <= shift_q;
                                ptr_q        <= ptr_q + 1'b1;
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            state_q   <= ST_WR_BYTE;
                            sda_q     <= 1'b1;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_RD_BYTE: begin
                        if (scl_rise && bit_cnt_q < BITS_PER_BYTE) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
                            state_q <= ST_RD_ACK;
                            sda_q   <= 1'b1;
                            ptr_q   <= ptr_q + 1'b1;
                        end else if (scl_fall && bit_cnt_q != 4'd0) begin
                            shift_q <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                            sda_q   <= shift_q[DATA_WIDTH-2];
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            master_ack_q <= sda_s;
                        end else if (scl_fall) begin
                            bit_cnt_q <= '0;
                            if (master_ack_q == ACK) begin
                                state_q     <= ST_RD_BYTE;
                                shift_q     <= mem_q[ptr_q];
                                sda_q       <= mem_q[ptr_q][DATA_WIDTH-1];
                                rd_strobe_q <= 1'b1;
                                rd_addr_q   <= ptr_q;
                            end else begin
                                state_q <= ST_IGNORE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_o       = sda_q;
    assign busy_o      = busy_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign rd_strobe_o = rd_strobe_q;
    assign rd_addr_o   = rd_addr_q;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// tb/tb_i2c_slave_mem.sv - bit-banged I2C master bench with reference model and strobe scoreboard
module tb_i2c_slave_mem;

    localparam int QP = 5;
    localparam logic [6:0] SADDR = 7'h22;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       dut_sda;
    logic       busy;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_strobe;
    logic [3:0] rd_addr;

    always #5 clk = ~clk;

    assign sda_bus = sda_m & dut_sda;

    i2c_slave_mem dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .scl_i       (scl_m),
        .sda_i       (sda_bus),
        .sda_o       (dut_sda),
        .busy_o      (busy),
        .wr_strobe_o (wr_strobe),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .rd_strobe_o (rd_strobe),
        .rd_addr_o   (rd_addr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int addr;
        int data;
    } wr_ev_t;

    wr_ev_t     exp_wr[$];
    int         exp_rd[$];
    logic [7:0] tx_q[$];
    logic [7:0] mdl_mem[16];
    int         mdl_ptr;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest outstanding expectation.
    initial begin
        wr_ev_t ev;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wr_strobe) begin
                    if (exp_wr.size() == 0) begin
                        check("unexpected_wr_strobe", 1, 0);
                    end else begin
                        ev = exp_wr.pop_front();
                        check("wr_addr", int'(wr_addr), ev.addr);
                        check("wr_data", int'(wr_data), ev.data);
                    end
                end
                if (rd_strobe) begin
                    if (exp_rd.size() == 0) begin
                        check("unexpected_rd_strobe", 1, 0);
                    end else begin
                        check("rd_addr", int'(rd_addr), exp_rd.pop_front());
                    end
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clk_bit(input logic v, output logic s);
        wait_clks(QP);
        sda_m = v;
        wait_clks(QP);
        scl_m = 1'b1;
        wait_clks(QP);
        s = sda_bus;
        wait_clks(QP);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        wait_clks(QP);
        sda_m = 1'b1;
        wait_clks(QP);
        scl_m = 1'b1;
        wait_clks(QP);
        sda_m = 1'b0;
        wait_clks(QP);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clks(QP);
        sda_m = 1'b0;
        wait_clks(QP);
        scl_m = 1'b1;
        wait_clks(QP);
        sda_m = 1'b1;
        wait_clks(QP);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            b[i] = s;
        end
        clk_bit(mack, s);
    endtask

    task automatic write_txn(input logic [6:0] a, input bit do_stop);
        logic ack;
        bit   hit;
        hit = (a == SADDR);
        i2c_start();
        write_byte({a, 1'b0}, ack);
        check("wr_addr_ack", int'(ack), hit ? 0 : 1);
        check("busy_after_addr", int'(busy), int'(hit));
        if (hit) begin
            foreach (tx_q[i]) begin
                if (i == 0) begin
                    mdl_ptr = int'(tx_q[0]) % 16;
                end else begin
                    exp_wr.push_back('{mdl_ptr, int'(tx_q[i])});
                    mdl_mem[mdl_ptr] = tx_q[i];
                    mdl_ptr = (mdl_ptr + 1) % 16;
                end
                write_byte(tx_q[i], ack);
                check("wr_data_ack", int'(ack), 0);
            end
        end
        if (do_stop) begin
            i2c_stop();
            wait_clks(4);
            check("busy_after_stop", int'(busy), 0);
        end
    endtask

    task automatic read_txn(input logic [6:0] a, input int n);
        logic       ack;
        logic [7:0] b;
        bit         hit;
        hit = (a == SADDR);
        i2c_start();
        if (hit) begin
            for (int k = 0; k < n; k++) exp_rd.push_back((mdl_ptr + k) % 16);
        end
        write_byte({a, 1'b1}, ack);
        check("rd_addr_ack", int'(ack), hit ? 0 : 1);
        check("busy_after_addr", int'(busy), int'(hit));
        if (hit) begin
            for (int k = 0; k < n; k++) begin
                read_byte((k == n - 1) ? 1'b1 : 1'b0, b);
                check("rd_data", int'(b), int'(mdl_mem[mdl_ptr]));
                mdl_ptr = (mdl_ptr + 1) % 16;
            end
        end
        i2c_stop();
        wait_clks(4);
        check("busy_after_stop", int'(busy), 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
        mdl_ptr = 0;
    endtask

    initial begin
        logic       ack;
        logic       s;
        int         op;
        int         n;
        logic [6:0] bad;

        model_reset();
        wait_clks(4);
        check("reset_sda_o", int'(dut_sda), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_wr_strobe", int'(wr_strobe), 0);
        check("reset_rd_strobe", int'(rd_strobe), 0);
        check("reset_wr_addr", int'(wr_addr), 0);
        check("reset_wr_data", int'(wr_data), 0);
        check("reset_rd_addr", int'(rd_addr), 0);
        rst = 1'b0;
        wait_clks(4);

        tx_q = {8'h03, 8'hA5, 8'h5A};
        write_txn(SADDR, 1'b1);

        tx_q = {8'h03};
        write_txn(SADDR, 1'b0);
        read_txn(SADDR, 2);

        tx_q = {8'h00};
        write_txn(7'h23, 1'b1);
        write_txn(7'h00, 1'b1);
        read_txn(7'h23, 2);

        tx_q = {8'h0F, 8'h11, 8'h22};
        write_txn(SADDR, 1'b1);
        tx_q = {8'h0F};
        write_txn(SADDR, 1'b1);
        read_txn(SADDR, 2);

        // Write aborted by STOP after four data bits.
        i2c_start();
        write_byte({SADDR, 1'b0}, ack);
        check("abort_addr_ack", int'(ack), 0);
        write_byte(8'h07, ack);
        mdl_ptr = 7;
        for (int i = 0; i < 4; i++) clk_bit(1'($urandom_range(0, 1)), s);
        i2c_stop();
        wait_clks(4);
        check("abort_busy", int'(busy), 0);
        read_txn(SADDR, 1);

        for (int t = 0; t < 25; t++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    tx_q = {8'($urandom_range(0, 255))};
                    n = $urandom_range(0, 3);
                    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
                    write_txn(SADDR, 1'b1);
                end
                1: begin
                    tx_q = {8'($urandom_range(0, 255))};
                    write_txn(SADDR, 1'b0);
                    read_txn(SADDR, $urandom_range(1, 3));
                end
                2: read_txn(SADDR, $urandom_range(1, 3));
                default: begin
                    bad = 7'($urandom_range(0, 127));
                    if (bad == SADDR) bad = 7'h00;
                    tx_q = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
                    if ($urandom_range(0, 1) == 0) write_txn(bad, 1'b1);
                    else read_txn(bad, 2);
                end
            endcase
        end

        // Reset while the slave is pulling sda low during a read data bit.
        tx_q = {8'h05, 8'h3C};
        write_txn(SADDR, 1'b1);
        tx_q = {8'h05};
        write_txn(SADDR, 1'b1);
        i2c_start();
        exp_rd.push_back(5);
        write_byte({SADDR, 1'b1}, ack);
        check("rst_test_addr_ack", int'(ack), 0);
        wait_clks(QP);
        check("rd_msb_driven_low", int'(dut_sda), 0);
        rst = 1'b1;
        #1;
        check("sda_released_on_reset", int'(dut_sda), 1);
        check("busy_cleared_on_reset", int'(busy), 0);
        wait_clks(2);
        rst = 1'b0;
        model_reset();
        i2c_stop();
        read_txn(SADDR, 4);
        tx_q = {8'h09, 8'hC3};
        write_txn(SADDR, 1'b1);
        tx_q = {8'h09};
        write_txn(SADDR, 1'b0);
        read_txn(SADDR, 1);

        wait_clks(20);
        check("wr_queue_drained", exp_wr.size(), 0);
        check("rd_queue_drained", exp_rd.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
